// File: rtl/twiddle_seq_pkg.sv
// Shared constants, marker type and index helpers for the 64-point radix-8 FFT
// inter-stage twiddle path.
package twiddle_seq_pkg;

  localparam int FRAME_LEN = 64;
  localparam int IDX_W     = 6;
  localparam int WIDTH_DEF = 14;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic v;
    logic sop;
    logic eop;
  } mark_t;

  // Radix-8 digit swap: n = 8*a + b maps to 8*b + a.
  function automatic logic [IDX_W-1:0] digit_swap(input logic [IDX_W-1:0] n);
    return {n[2:0], n[5:3]};
  endfunction

endpackage

// File: rtl/twiddle_seq_round_sat.sv
// Combinational WIDTH+2 -> WIDTH requantizer: round half up (add 2, arithmetic
// shift by 2), then clamp to the signed WIDTH range and flag the clamp.
module fft_round_sat #(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH+1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  localparam int XW = WIDTH + 2;

  logic signed [XW:0]         sum;
  logic signed [XW:0]         shr;
  logic        [XW-WIDTH+1:0] hi;

  // One guard bit keeps the +2 from wrapping at the positive full-scale input.
  assign sum = $signed({x[XW-1], x} + (XW+1)'(2));
  assign shr = sum >>> 2;
  assign hi  = shr[XW:WIDTH-1];
  assign sat = !((&hi) || !(|hi));

  always_comb begin
    if (!sat)
      y = shr[WIDTH-1:0];
    else if (shr[XW])
      y = {1'b1, {(WIDTH-1){1'b0}}};
    else
      y = {1'b0, {(WIDTH-1){1'b1}}};
  end

endmodule

// File: rtl/twiddle_seq.sv
// Frame sequencer and requantizer around the inter-stage twiddle multiplier:
// indexes samples, feeds the multiplier, realigns markers and rounds the result.
module twiddle_seq
  import twiddle_seq_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MULT_LAT = 1,
  parameter int ORDER    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic [5:0]       mult_cnt,
  output logic [WIDTH-1:0] mult_re,
  output logic [WIDTH-1:0] mult_im,
  input  logic [WIDTH+1:0] mult_out_re,
  input  logic [WIDTH+1:0] mult_out_im,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             frame_err,
  output logic             sat_flag
);

  logic [0:0]       state;
  logic [IDX_W-1:0] n;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             proto_err;
  mark_t            mark_a;
  mark_t            mark_d;
  mark_t            dly [MULT_LAT];
  logic [WIDTH-1:0] y_re, y_im;
  logic             sat_re, sat_im, sat_any;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    idx       = in_sop ? '0 : n;
    accept    = in_valid && (in_sop || state == ST_RUN);
    proto_err = in_valid && ((state == ST_IDLE && !in_sop) ||
                             (state == ST_RUN && in_sop && n != '0));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      n         <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= proto_err;
      if (accept) begin
        if (idx == LAST_IDX) begin
          state <= ST_IDLE;
          n     <= '0;
        end else begin
          state <= ST_RUN;
          n     <= idx + IDX_W'(1);
        end
      end
    end
  end

  // Stage A: multiplier operands hold between accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_cnt <= '0;
      mult_re  <= '0;
      mult_im  <= '0;
      mark_a   <= '0;
    end else begin
      mark_a <= '{v: accept, sop: accept && idx == '0, eop: accept && idx == LAST_IDX};
      if (accept) begin
        mult_cnt <= (ORDER == 1) ? digit_swap(idx) : idx;
        mult_re  <= in_re;
        mult_im  <= in_im;
      end
    end
  end

  // NOTE: the marker delay line is a handful of flops, not a RAM, so resetting it is cheap
  // and guarantees no stale marker escapes after a mid-frame reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MULT_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= mark_a;
      for (int i = 1; i < MULT_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign mark_d = dly[MULT_LAT-1];

  fft_round_sat #(.WIDTH(WIDTH)) u_rs_re (.x(mult_out_re), .y(y_re), .sat(sat_re));
  fft_round_sat #(.WIDTH(WIDTH)) u_rs_im (.x(mult_out_im), .y(y_im), .sat(sat_im));

  assign sat_any = sat_re || sat_im;

  // Stage C: data holds across bubbles; sat_flag restarts with each output frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= mark_d.v;
      out_sop   <= mark_d.sop;
      out_eop   <= mark_d.eop;
      if (mark_d.v) begin
        out_re <= y_re;
        out_im <= y_im;
        if (mark_d.sop)
          sat_flag <= sat_any;
        else if (sat_any)
          sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq: a registered multiplier model that returns the
// sign-extended operand (or a forced value), with an ORDER=1 twin checking the index map.
module tb_twiddle_seq;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_sop = 1'b0;
  logic [W-1:0] in_re = '0, in_im = '0;
  logic [W+1:0] mult_out_re, mult_out_im;

  logic [5:0]   mult_cnt, mult_cnt1;
  logic [W-1:0] mult_re, mult_im, mult_re1, mult_im1;
  logic         out_valid, out_sop, out_eop, frame_err, sat_flag;
  logic [W-1:0] out_re, out_im;
  logic         out_valid1, out_sop1, out_eop1, frame_err1, sat_flag1;
  logic [W-1:0] out_re1, out_im1;

  always #5 clk = ~clk;

  twiddle_seq #(.WIDTH(W), .MULT_LAT(1), .ORDER(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_re(in_re), .in_im(in_im), .mult_cnt(mult_cnt), .mult_re(mult_re),
    .mult_im(mult_im), .mult_out_re(mult_out_re), .mult_out_im(mult_out_im),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_re(out_re), .out_im(out_im), .frame_err(frame_err), .sat_flag(sat_flag));

  twiddle_seq #(.WIDTH(W), .MULT_LAT(1), .ORDER(1)) dut_swap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_re(in_re), .in_im(in_im), .mult_cnt(mult_cnt1), .mult_re(mult_re1),
    .mult_im(mult_im1), .mult_out_re(mult_out_re), .mult_out_im(mult_out_im),
    .out_valid(out_valid1), .out_sop(out_sop1), .out_eop(out_eop1),
    .out_re(out_re1), .out_im(out_im1), .frame_err(frame_err1), .sat_flag(sat_flag1));

  // Unity multiplier with one register of latency, plus a real-part override.
  logic [W+1:0] mreg_re = '0, mreg_im = '0;
  logic         force_en = 1'b0;
  logic [W+1:0] force_val = '0;

  always @(posedge clk) begin
    mreg_re <= {{2{mult_re[W-1]}}, mult_re};
    mreg_im <= {{2{mult_im[W-1]}}, mult_im};
  end
  assign mult_out_re = force_en ? force_val : mreg_re;
  assign mult_out_im = mreg_im;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int cyc = 0;
  int o_re[$], o_im[$], o_cyc[$];
  bit o_sop[$], o_eop[$], o_sat[$];
  int err_cnt = 0, hold_bad = 0;
  logic [W-1:0] last_re = '0, last_im = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) begin
      o_re.push_back($signed(out_re));
      o_im.push_back($signed(out_im));
      o_sop.push_back(out_sop);
      o_eop.push_back(out_eop);
      o_sat.push_back(sat_flag);
      o_cyc.push_back(cyc);
    end else if (rst_n && (out_re != last_re || out_im != last_im)) begin
      hold_bad++;
    end
    if (frame_err) err_cnt++;
    last_re = out_re;
    last_im = out_im;
  end

  function automatic int swap_ref(input int n);
    return (n % 8) * 8 + n / 8;
  endfunction

  function automatic int count_set(input bit q[$]);
    int c = 0;
    foreach (q[i]) if (q[i]) c++;
    return c;
  endfunction

  task automatic clear_mon();
    o_re.delete(); o_im.delete(); o_cyc.delete();
    o_sop.delete(); o_eop.delete(); o_sat.delete();
    err_cnt = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  int drive_cyc;

  // Presents one sample for one cycle; exp_n < 0 means the sample must be dropped.
  task automatic send(input int re, input int im, input bit sop, input int exp_n);
    in_valid = 1'b1; in_sop = sop; in_re = W'(re); in_im = W'(im);
    drive_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0;
    if (exp_n >= 0) begin
      check("cnt_order0", mult_cnt, exp_n);
      check("cnt_order1", mult_cnt1, swap_ref(exp_n));
    end
  endtask

  int t1_drive, bad;

  initial begin
    // Reset state
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_cnt", mult_cnt, 0);
    check("rst_out_re", out_re, 0);
    check("rst_err", frame_err, 0);
    check("rst_sat", sat_flag, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    clear_mon();

    // 1/2: unity path, index sequences in both orders
    for (int n = 0; n < 64; n++) begin
      send(1000, -1000, n == 0, n);
      if (n == 0) t1_drive = drive_cyc;
      if (n == 9)  check("ord1_n9", mult_cnt1, 9);
      if (n == 10) check("ord1_n10", mult_cnt1, 17);
      if (n == 63) check("ord1_n63", mult_cnt1, 63);
    end
    idle(8);
    check("t1_count", o_re.size(), 64);
    bad = 0;
    foreach (o_re[i]) if (o_re[i] != 250 || o_im[i] != -250) bad++;
    check("t1_data_bad", bad, 0);
    check("t1_sop_first", o_sop.size() > 0 ? o_sop[0] : 0, 1);
    check("t1_eop_last", o_eop.size() == 64 ? o_eop[63] : 0, 1);
    check("t1_sop_count", count_set(o_sop), 1);
    check("t1_eop_count", count_set(o_eop), 1);
    check("t1_latency", o_cyc.size() > 0 ? o_cyc[0] - t1_drive : -1, 3);
    check("t1_sat", sat_flag, 0);
    check("t1_err", err_cnt, 0);
    clear_mon();

    // 3: positive full scale saturates, including on the sop sample
    force_en = 1'b1; force_val = 16'sd32767;
    for (int n = 0; n < 64; n++) send(0, 0, n == 0, n);
    idle(8);
    check("t3a_count", o_re.size(), 64);
    check("t3a_re", o_re.size() > 0 ? o_re[0] : 0, 8191);
    check("t3a_sat_at_sop", o_sat.size() > 0 ? o_sat[0] : 0, 1);
    check("t3a_sat_end", sat_flag, 1);
    clear_mon();

    // Negative full scale fits exactly; sat_flag clears at the new out_sop
    force_val = 16'h8000;
    for (int n = 0; n < 64; n++) send(0, 0, n == 0, n);
    idle(8);
    check("t3b_re_first", o_re.size() > 0 ? o_re[0] : 0, -8192);
    check("t3b_re_last", o_re.size() == 64 ? o_re[63] : 0, -8192);
    check("t3b_sat_at_sop", o_sat.size() > 0 ? o_sat[0] : 1, 0);
    check("t3b_sat_end", sat_flag, 0);
    force_en = 1'b0;
    clear_mon();

    // 4a: second in_sop at n=20 restarts the frame
    for (int n = 0; n < 20; n++) send(400, -400, n == 0, n);
    send(400, -400, 1'b1, 0);
    for (int n = 1; n < 64; n++) send(400, -400, 1'b0, n);
    idle(8);
    check("t4a_err_pulses", err_cnt, 1);
    check("t4a_count", o_re.size(), 84);
    check("t4a_sop_count", count_set(o_sop), 2);
    check("t4a_sop_restart", o_sop.size() > 20 ? o_sop[20] : 0, 1);
    check("t4a_eop_count", count_set(o_eop), 1);
    check("t4a_eop_pos", o_eop.size() == 84 ? o_eop[83] : 0, 1);
    check("t4a_re", o_re.size() > 0 ? o_re[0] : 0, 100);
    check("t4a_im", o_im.size() > 0 ? o_im[0] : 0, -100);
    clear_mon();

    // 4b: valid without sop while idle is dropped
    send(123, 456, 1'b0, -1);
    check("t4b_cnt_hold", mult_cnt, 63);
    idle(8);
    check("t4b_err_pulses", err_cnt, 1);
    check("t4b_no_output", o_re.size(), 0);
    clear_mon();

    // 5: random bubbles inside a frame
    hold_bad = 0;
    for (int n = 0; n < 64; n++) begin
      send(16 * n - 500, -(4 * n + 3), n == 0, n);
      idle($urandom_range(0, 3));
    end
    idle(8);
    check("t5_count", o_re.size(), 64);
    bad = 0;
    foreach (o_re[i]) if (o_re[i] != 4 * i - 125 || o_im[i] != -(i + 1)) bad++;
    check("t5_data_bad", bad, 0);
    check("t5_eop_count", count_set(o_eop), 1);
    check("t5_eop_pos", o_eop.size() == 64 ? o_eop[63] : 0, 1);
    check("t5_hold_bad", hold_bad, 0);
    check("t5_err", err_cnt, 0);
    clear_mon();

    // 6: reset at n=30 discards the frame
    for (int n = 0; n < 30; n++) send(200, 200, n == 0, n);
    check("t6_inflight", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_cnt", mult_cnt, 0);
    check("t6_rst_mult_re", mult_re, 0);
    check("t6_rst_out_re", out_re, 0);
    check("t6_rst_out_im", out_im, 0);
    clear_mon();
    idle(2);
    rst_n = 1'b1;
    idle(8);
    check("t6_no_output", o_re.size(), 0);
    check("t6_no_eop", count_set(o_eop), 0);
    for (int n = 0; n < 64; n++) send(-200, 200, n == 0, n);
    idle(8);
    check("t6_count", o_re.size(), 64);
    check("t6_re", o_re.size() > 0 ? o_re[0] : 0, -50);
    check("t6_sop", o_sop.size() > 0 ? o_sop[0] : 0, 1);
    check("t6_eop_pos", o_eop.size() == 64 ? o_eop[63] : 0, 1);
    check("t6_eop_count", count_set(o_eop), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
